// File: rtl/galaxian_dl_pkg.sv
// Shared constants for the Galaxian download/configuration sequencer:
// ioctl target indices, sequencer states and game-select codes.
package galaxian_dl_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ROM_DL  = 3'd1;
  localparam logic [2:0] ST_CFG_DL  = 3'd2;
  localparam logic [2:0] ST_DIP_DL  = 3'd3;
  localparam logic [2:0] ST_SKIP_DL = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ROM_DL  = ST_ROM_DL,
    CFG_DL  = ST_CFG_DL,
    DIP_DL  = ST_DIP_DL,
    SKIP_DL = ST_SKIP_DL,
    HOLD    = ST_HOLD
  } dl_state_e;

  localparam logic [7:0] MOD_GALAXIAN  = 8'd0;
  localparam logic [7:0] MOD_MOONCRST  = 8'd1;
  localparam logic [7:0] MOD_AZURIAN   = 8'd2;
  localparam logic [7:0] MOD_BLACKHOLE = 8'd3;
  localparam logic [7:0] MOD_CATACOMB  = 8'd4;
  localparam logic [7:0] MOD_CHEWINGG  = 8'd5;
  localparam logic [7:0] MOD_DEVILFSH  = 8'd6;
  localparam logic [7:0] MOD_KINGBAL   = 8'd7;
  localparam logic [7:0] MOD_MRDONIGH  = 8'd8;
  localparam logic [7:0] MOD_OMEGA     = 8'd9;
  localparam logic [7:0] MOD_ORBITRON  = 8'd10;
  localparam logic [7:0] MOD_PISCES    = 8'd11;
  localparam logic [7:0] MOD_UNIWARS   = 8'd12;
  localparam logic [7:0] MOD_VICTORY   = 8'd13;
  localparam logic [7:0] MOD_WAROFBUG  = 8'd14;
  localparam logic [7:0] MOD_ZIGZAG    = 8'd15;
  localparam logic [7:0] MOD_TRIPLEDR  = 8'd16;
  localparam logic [7:0] MOD_LUCKTODAY = 8'd17;

  // Unknown game codes fall back to Galaxian.
  function automatic logic [7:0] mod_clamp(input logic [7:0] v, input int count);
    return (int'(v) < count) ? v : MOD_GALAXIAN;
  endfunction

endpackage

// File: rtl/galaxian_reset_stretch.sv
// Core-reset hold counter: counts down while enabled, reloads on request,
// and pulses done in the cycle the count leaves 1.
module galaxian_reset_stretch
  import galaxian_dl_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic reload_i,
  output logic done_o
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    done_o  = 1'b0;
    if (reload_i) begin
      count_d = HOLD_INIT;
    end else if (en_i) begin
      if (count_q == 8'd1) begin
        done_o  = 1'b1;
        count_d = HOLD_INIT;
      end else begin
        count_d = count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= HOLD_INIT;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// Download/configuration sequencer between the HPS ioctl stream and the
// Galaxian core: ROM write port, game select, DIP bytes and core reset.
module galaxian_dl_ctrl
  import galaxian_dl_pkg::*;
#(
  parameter int ROM_AW      = 16,
  parameter int HOLD_CYCLES = 16,
  parameter int DIP_BYTES   = 8,
  parameter int MOD_COUNT   = 18
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  input  logic                   user_reset,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   rom_wr,
  output logic [7:0]             mod_id,
  output logic [MOD_COUNT-1:0]   mod_onehot,
  output logic [8*DIP_BYTES-1:0] dip_bus,
  output logic                   core_reset,
  output logic                   rom_overflow,
  output logic [2:0]             dl_state
);

  dl_state_e state_q, state_d;
  logic boot_q, dl_q, core_reset_q;
  logic rom_wr_q, rom_ovf_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [7:0] rom_data_q, mod_id_q;
  logic [MOD_COUNT-1:0] mod_onehot_q, mod_onehot_d;
  logic [8*DIP_BYTES-1:0] dip_q;

  logic dl_rise, rom_in_range, rom_accept, rom_drop, rom_entry;
  logic hold_en, hold_reload, hold_done;

  // dl_q resets high so a download already in progress at reset release
  // is not mistaken for a fresh start.
  assign dl_rise      = ioctl_download & ~dl_q;
  assign rom_in_range = {7'd0, ioctl_addr} < (32'd1 << ROM_AW);
  assign rom_accept   = (state_q == ROM_DL) && ioctl_wr && rom_in_range;
  assign rom_drop     = (state_q == ROM_DL) && ioctl_wr && !rom_in_range;
  assign rom_entry    = (state_d == ROM_DL) && (state_q != ROM_DL);

  // The first cycle after reset release counts as HOLD so the core sees
  // exactly HOLD_CYCLES cycles of reset.
  assign hold_en     = (state_q == HOLD) || boot_q;
  assign hold_reload = !hold_en || user_reset || (dl_rise && ioctl_index == IDX_ROM);

  galaxian_reset_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .en_i    (hold_en),
    .reload_i(hold_reload),
    .done_o  (hold_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (boot_q) begin
          state_d = HOLD;
        end else if (dl_rise) begin
          if (ioctl_index == IDX_ROM)      state_d = ROM_DL;
          else if (ioctl_index == IDX_MOD) state_d = CFG_DL;
          else if (ioctl_index == IDX_DIP) state_d = DIP_DL;
          else                             state_d = SKIP_DL;
        end else if (user_reset) begin
          state_d = HOLD;
        end
      end
      ROM_DL:  if (!ioctl_download) state_d = HOLD;
      CFG_DL:  if (!ioctl_download) state_d = HOLD;
      DIP_DL:  if (!ioctl_download) state_d = IDLE;
      SKIP_DL: if (!ioctl_download) state_d = IDLE;
      HOLD: begin
        if (dl_rise && ioctl_index == IDX_ROM) state_d = ROM_DL;
        else if (hold_done)                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      boot_q       <= 1'b1;
      dl_q         <= 1'b1;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      boot_q       <= 1'b0;
      dl_q         <= ioctl_download;
      core_reset_q <= (state_d == ROM_DL) || (state_d == HOLD);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_wr_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= 8'd0;
      rom_ovf_q  <= 1'b0;
    end else begin
      rom_wr_q <= rom_accept;
      if (rom_accept) begin
        rom_addr_q <= ioctl_addr[ROM_AW-1:0];
        rom_data_q <= ioctl_dout;
      end
      if (rom_entry)     rom_ovf_q <= 1'b0;
      else if (rom_drop) rom_ovf_q <= 1'b1;
    end
  end

  always_comb begin
    mod_onehot_d = '0;
    for (int k = 0; k < MOD_COUNT; k++) begin
      mod_onehot_d[k] = (mod_id_q == 8'(k));
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod_id_q     <= MOD_GALAXIAN;
      mod_onehot_q <= MOD_COUNT'(1);
      dip_q        <= '1;
    end else begin
      if (state_q == CFG_DL && ioctl_wr && ioctl_addr == 25'd0) begin
        mod_id_q <= mod_clamp(ioctl_dout, MOD_COUNT);
      end
      mod_onehot_q <= mod_onehot_d;
      for (int n = 0; n < DIP_BYTES; n++) begin
        if (state_q == DIP_DL && ioctl_wr && ioctl_addr == 25'(n)) begin
          dip_q[8*n +: 8] <= ioctl_dout;
        end
      end
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign rom_wr       = rom_wr_q;
  assign rom_overflow = rom_ovf_q;
  assign mod_id       = mod_id_q;
  assign mod_onehot   = mod_onehot_q;
  assign dip_bus      = dip_q;
  assign core_reset   = core_reset_q;
  assign dl_state     = state_q;

endmodule

// File: doc/galaxian_dl_ctrl.md
Name: galaxian_dl_ctrl

Overview:
- Download and configuration sequencer between the HPS ioctl stream and the Galaxian core.
- Routes index 0 bytes to the program/graphics ROM write port. Latches the game-select byte (index 1) and the DIP bytes (index 254).
- Holds the core in reset while ROM loads. Generates a stretched core reset after ROM load completes and on user reset requests.
- Replaces the ad-hoc download decoding in the core top level.

Parameters:
- ROM_AW, 16, ROM address width; ioctl addresses at or above 2^ROM_AW are dropped.
- HOLD_CYCLES, 16, clk_sys cycles core_reset stays high after a ROM load or user reset; legal range 2..255.
- DIP_BYTES, 8, number of DIP bytes stored (index 254, addr 0..DIP_BYTES-1).
- MOD_COUNT, 18, number of valid game-select codes.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  byte strobe, one clk_sys cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target.
- user_reset  in  1  OSD/button reset request, level.
- rom_addr  out  ROM_AW  ROM write address.
- rom_data  out  8  ROM write data.
- rom_wr  out  1  ROM write strobe.
- mod_id  out  8  selected game code.
- mod_onehot  out  MOD_COUNT  decoded game select; bit k high when mod_id==k.
- dip_bus  out  8*DIP_BYTES  DIP bytes; byte n is at bits [8n+7:8n].
- core_reset  out  1  active-high reset to the core.
- rom_overflow  out  1  sticky flag: a ROM write was dropped for being out of range.

Behaviour:
- Reset (reset_n low, async) sets:
  - state=IDLE; rom_wr=0; rom_addr=0; rom_data=0.
  - mod_id=0; mod_onehot=1 (galaxian).
  - dip_bus all 0xFF, so inputs ANDed with it pass through.
  - core_reset=1; hold counter=HOLD_CYCLES; rom_overflow=0.
- After reset release the FSM enters HOLD first. core_reset therefore drops exactly HOLD_CYCLES cycles after reset_n rises.
- ioctl_index is latched on the rising edge of ioctl_download (edge detect on a registered copy). Index changes during a download are ignored.
- States and transitions:
  - IDLE: core_reset=0.
    - Download rise with index 0 -> ROM_DL.
    - Download rise with index 1 -> CFG_DL.
    - Download rise with index 254 -> DIP_DL.
    - Download rise with any other index -> SKIP_DL.
    - user_reset -> HOLD.
  - ROM_DL: core_reset=1; rom_overflow cleared on entry.
    - Each ioctl_wr with addr < 2^ROM_AW: rom_wr=1 the next cycle, with rom_addr=addr[ROM_AW-1:0] and rom_data=dout. Latency is exactly 1 cycle.
    - Writes with addr at or above 2^ROM_AW are dropped and set rom_overflow.
    - ioctl_download falls -> HOLD.
  - CFG_DL: core_reset unchanged (0).
    - Only the ioctl_wr at addr 0 updates mod_id.
    - A value at or above MOD_COUNT is stored as 0.
    - mod_onehot is registered from mod_id, one cycle after mod_id.
    - Download falls -> HOLD; a game change always resets the core.
  - DIP_DL: core_reset=0.
    - An ioctl_wr with addr < DIP_BYTES writes dip_bus byte addr[2:0], visible the next cycle.
    - Other addresses are ignored.
    - Download falls -> IDLE; no core reset.
  - SKIP_DL: core_reset=0; all writes ignored. Download falls -> IDLE.
  - HOLD: core_reset=1; counter decrements each cycle.
    - Counter reaches 1 -> IDLE, with counter reloaded to HOLD_CYCLES.
    - user_reset high, or a download rise with index 0, reloads the counter (index 0 rise goes to ROM_DL).
- rom_wr is high only in the cycle after an accepted ROM write, never two cycles per byte.
- user_reset held high keeps the FSM in HOLD indefinitely. user_reset is ignored in ROM_DL, because the core is already held in reset.
- ioctl_download is deasserted while ioctl_wr is high in the same cycle: the write is still accepted, then the transition happens.
- reset_n asserted mid-download: everything returns to reset values. If ioctl_download is still high after release, no download is entered (no rising edge seen) and its bytes are ignored until the next rise.
- rom_overflow persists until the next ROM_DL entry or reset.

Decomposition:
- Package galaxian_dl_pkg holds:
  - Index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254.
  - The state enum {IDLE, ROM_DL, CFG_DL, DIP_DL, SKIP_DL, HOLD}.
  - Game code constants MOD_GALAXIAN=0 through MOD_LUCKTODAY=17.
- One natural sub-module, galaxian_reset_stretch: the HOLD counter, reload on request, with a done pulse. All else is flat.

Test Plan:
- Release reset_n with no activity -> core_reset high for exactly 16 cycles, then 0; dip_bus=all 0xFF; mod_onehot=18'h00001.
- Index 0 download of 4 bytes at addr 0..3, data A5,5A,FF,00 -> rom_wr pulses 1 cycle after each ioctl_wr with matching addr/data; core_reset=1 throughout; after download falls, core_reset=1 for 16 more cycles; rom_overflow=0.
- Index 0 write at addr 0x10000 -> no rom_wr; rom_overflow=1; next index 0 download clears it on entry.
- Index 1 download, byte 0x0C at addr 0, then 0x03 at addr 1 -> mod_id=12, mod_onehot bit 12 only. Byte 0x20 at addr 0 -> mod_id=0. Each download end yields a 16-cycle core_reset.
- Index 254 download, bytes 11..88 at addr 0..7 plus addr 8 -> dip_bus=64'h8877665544332211 with addr 8 ignored; core_reset never asserted.
- user_reset pulse during HOLD at count 5 -> counter reloads, reset lasts 16 cycles from the pulse. reset_n low mid-ROM download -> immediate reset values; later bytes with download still high produce no rom_wr.
